// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory bus between the fetch stage (master) and imem (slave).
interface fetch_stage_if #(parameter int AW = 32, parameter int IW = 32);
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    modport master (output imem_addr, input imem_rdata);
    modport slave (input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction fetch and IF/ID register with jump/branch redirect and stall.
// Optional perf counters built when FETCH_PERF_EN is defined.
module fetch_stage #(
    parameter int AW = 32,
    parameter int IW = 32,
    parameter int PC_STEP = 4,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [IW-1:0] NOP_INSTR = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall_i,
    input  logic [1:0]    jmp_sel_i,
    input  logic [AW-1:0] jmp_target_i,
    input  logic [AW-1:0] jr_target_i,
    input  logic          branch_taken_i,
    input  logic [AW-1:0] branch_target_i,
    fetch_stage_if.master imem,
    output logic          if_id_valid_o,
    output logic [IW-1:0] if_id_instr_o,
    output logic [AW-1:0] if_id_pc_o,
    output logic [AW-1:0] if_id_pc4_o,
    output logic [4:0]    opcode_o,
    output logic [2:0]    aluop_o,
    output logic [31:0]   perf_fetch_o,
    output logic [31:0]   perf_bubble_o
);
    logic [AW-1:0] pc_q, pc_d, pc_plus;
    logic          load, redirect;
    logic          valid_q;
    logic [IW-1:0] instr_q;
    logic [AW-1:0] ifpc_q, ifpc4_q;

    assign pc_plus = pc_q + AW'(PC_STEP);
    // A taken branch loads even while stalled; JMP/JR only count when not stalled.
    assign load = branch_taken_i | ~stall_i;
    assign redirect = branch_taken_i | (~stall_i & (jmp_sel_i == 2'b01 | jmp_sel_i == 2'b10));

    always_comb begin
        pc_d = branch_taken_i ? branch_target_i :
               stall_i ? pc_q :
               jmp_sel_i == 2'b01 ? jmp_target_i :
               jmp_sel_i == 2'b10 ? jr_target_i : pc_plus;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            ifpc_q <= '0;
            ifpc4_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (load) begin
                valid_q <= ~redirect;
                instr_q <= redirect ? NOP_INSTR : imem.imem_rdata;
                ifpc_q <= pc_q;
                ifpc4_q <= pc_plus;
            end
        end
    end

    assign imem.imem_addr = pc_q;
    assign if_id_valid_o = valid_q;
    assign if_id_instr_o = instr_q;
    assign if_id_pc_o = ifpc_q;
    assign if_id_pc4_o = ifpc4_q;
    assign opcode_o = instr_q[IW-1 -: 5];
    assign aluop_o = instr_q[2:0];

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_q, bubble_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_q <= '0;
            bubble_q <= '0;
        end else if (load) begin
            if (!redirect && fetch_q != '1) fetch_q <= fetch_q + 32'd1;
            if (redirect && bubble_q != '1) bubble_q <= bubble_q + 32'd1;
        end
    end
    assign perf_fetch_o = fetch_q;
    assign perf_bubble_o = bubble_q;
`else
    assign perf_fetch_o = '0;
    assign perf_bubble_o = '0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, wrap check and randomized run against a reference model.
module tb_fetch_stage;
    logic clk = 1'b0, rst_n = 1'b0;
    logic stall = 1'b0, br = 1'b0;
    logic [1:0] jsel = 2'b00;
    logic [31:0] jt = '0, jrt = '0, bt = '0;
    logic v1, v2;
    logic [31:0] ins1, pc1, pc41, pf1, pb1, ins2, pc2, pc42, pf2, pb2;
    logic [4:0] op1, op2;
    logic [2:0] al1, al2;
    int tests = 0, fails = 0;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    fetch_stage_if #(.AW(32), .IW(32)) mem1 ();
    fetch_stage_if #(.AW(32), .IW(32)) mem2 ();
    assign mem1.imem_rdata = tag(mem1.imem_addr);
    assign mem2.imem_rdata = tag(mem2.imem_addr);

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .jmp_sel_i(jsel), .jmp_target_i(jt),
        .jr_target_i(jrt), .branch_taken_i(br), .branch_target_i(bt), .imem(mem1.master),
        .if_id_valid_o(v1), .if_id_instr_o(ins1), .if_id_pc_o(pc1), .if_id_pc4_o(pc41),
        .opcode_o(op1), .aluop_o(al1), .perf_fetch_o(pf1), .perf_bubble_o(pb1));

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .stall_i(1'b0), .jmp_sel_i(2'b00), .jmp_target_i(32'h0),
        .jr_target_i(32'h0), .branch_taken_i(1'b0), .branch_target_i(32'h0), .imem(mem2.master),
        .if_id_valid_o(v2), .if_id_instr_o(ins2), .if_id_pc_o(pc2), .if_id_pc4_o(pc42),
        .opcode_o(op2), .aluop_o(al2), .perf_fetch_o(pf2), .perf_bubble_o(pb2));

    logic [31:0] m_pc, m_ins, m_ipc, m_ipc4;
    logic m_v;
    longint m_nf, m_nb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_v = 1'b0; m_ins = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
        m_nf = 0; m_nb = 0;
    endtask

    task automatic model_bubble();
        m_v = 1'b0; m_ins = 32'h0; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_nb++;
    endtask

    task automatic check_all();
        chk("addr", mem1.imem_addr, m_pc);
        chk("valid", 32'(v1), 32'(m_v));
        chk("instr", ins1, m_ins);
        chk("if_pc", pc1, m_ipc);
        chk("if_pc4", pc41, m_ipc4);
        chk("opcode", 32'(op1), 32'(m_ins[31:27]));
        chk("aluop", 32'(al1), 32'(m_ins[2:0]));
        chk("perf_fetch", pf1, PERF ? 32'(m_nf > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : m_nf) : 32'h0);
        chk("perf_bubble", pb1, PERF ? 32'(m_nb > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : m_nb) : 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        if (br) begin
            model_bubble();
            m_pc = bt;
        end else if (!stall) begin
            if (jsel == 2'b01) begin
                model_bubble();
                m_pc = jt;
            end else if (jsel == 2'b10) begin
                model_bubble();
                m_pc = jrt;
            end else begin
                m_v = 1'b1; m_ins = tag(m_pc); m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_nf++;
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic stall; logic [1:0] jsel; logic [31:0] jt, jrt; logic br; logic [31:0] bt;
        logic [31:0] e_addr; logic e_valid; logic [31:0] e_pc;
    } vec_t;
    vec_t vt[14];

    initial begin
        vt[0]  = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h004, 1'b1, 32'h000};
        vt[1]  = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h008, 1'b1, 32'h004};
        vt[2]  = '{1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h008, 1'b1, 32'h004};
        vt[3]  = '{1'b1, 2'b01, 32'h300, 32'h0, 1'b0, 32'h0, 32'h008, 1'b1, 32'h004};
        vt[4]  = '{1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h008, 1'b1, 32'h004};
        vt[5]  = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h00C, 1'b1, 32'h008};
        vt[6]  = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h010, 1'b1, 32'h00C};
        vt[7]  = '{1'b0, 2'b01, 32'h100, 32'h0, 1'b0, 32'h0, 32'h100, 1'b0, 32'h010};
        vt[8]  = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h104, 1'b1, 32'h100};
        vt[9]  = '{1'b1, 2'b10, 32'h0, 32'h200, 1'b1, 32'h40, 32'h040, 1'b0, 32'h104};
        vt[10] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h044, 1'b1, 32'h040};
        vt[11] = '{1'b0, 2'b11, 32'h500, 32'h600, 1'b0, 32'h0, 32'h048, 1'b1, 32'h044};
        vt[12] = '{1'b0, 2'b10, 32'h0, 32'h203, 1'b0, 32'h0, 32'h203, 1'b0, 32'h048};
        vt[13] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h207, 1'b1, 32'h203};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            stall = vt[i].stall; jsel = vt[i].jsel; jt = vt[i].jt; jrt = vt[i].jrt;
            br = vt[i].br; bt = vt[i].bt;
            step();
            chk("tbl_addr", mem1.imem_addr, vt[i].e_addr);
            chk("tbl_valid", 32'(v1), 32'(vt[i].e_valid));
            chk("tbl_pc", pc1, vt[i].e_pc);
            chk("tbl_pc4", pc41, vt[i].e_pc + 32'd4);
            chk("tbl_instr", ins1, vt[i].e_valid ? tag(vt[i].e_pc) : 32'h0);
        end
        chk("tbl_perf_fetch", pf1, PERF ? 32'd8 : 32'd0);
        chk("tbl_perf_bubble", pb1, PERF ? 32'd3 : 32'd0);

        // reset asserted while stalled must clear state without a clock edge
        stall = 1'b1; br = 1'b0; jsel = 2'b00;
        step();
        do_reset();
        stall = 1'b0;

        chk("wrap_rst_addr", mem2.imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_valid", 32'(v2), 32'd1);
        chk("wrap_pc", pc2, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc42, 32'h0);
        chk("wrap_instr", ins2, tag(32'hFFFF_FFFC));
        chk("wrap_addr", mem2.imem_addr, 32'h0);
        step();
        chk("wrap_pc_next", pc2, 32'h0);
        chk("wrap_pc4_next", pc42, 32'h4);

        do_reset();
        for (int i = 0; i < 600; i++) begin
            stall = ($urandom_range(3) == 0);
            br = ($urandom_range(7) == 0);
            jsel = 2'($urandom_range(3));
            jt = ($urandom_range(1) == 0) ? 32'hFFFF_FFF0 : $urandom;
            jrt = $urandom;
            bt = $urandom_range(255) << 2;
            if ($urandom_range(3) != 0) jsel = 2'b00;
            step();
        end
        stall = 1'b0; br = 1'b0; jsel = 2'b00;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
